// File: rtl/div_4bit_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH : default operand/result width
//   state_t   : controller states (IDLE, CALC, DONE)
package div_4bit_seq_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   partial      : current partial remainder (always < divisor, so WIDTH bits suffice)
//   dividend_bit : next dividend bit, MSB first
//   divisor      : divisor
//   next_partial : partial remainder after this step
//   q_bit        : quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] partial,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_partial,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The shifted value is below 2*divisor, so the WIDTH+1-bit difference
    // stays within signed range and its top bit is a reliable sign.
    assign shifted = {partial, dividend_bit};
    assign trial   = shifted + ~{1'b0, divisor} + {{WIDTH{1'b0}}, 1'b1};

    assign q_bit        = ~trial[WIDTH];
    // A non-negative trial always fits back into WIDTH bits (it is < divisor);
    // a negative one restores the shifted value, which is also < divisor.
    assign next_partial = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_4bit_seq.sv
// Sequential unsigned divider: one restoring step per clock.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : request, sampled in IDLE or DONE
//   A, B        : dividend, divisor (captured on accept)
//   Q, R        : quotient, remainder (held until the next result)
//   busy        : high while in CALC
//   done        : one-cycle pulse in DONE
//   div_by_zero : set with a B=0 result, held with Q/R
// A zero divisor skips CALC: the operands are captured on accept, the result
// is produced one cycle later and DONE follows directly.
module div_4bit_seq
    import div_4bit_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int             CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] dividend;    // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] step_partial;
    logic             q_bit;
    logic [CNT_W-1:0] count;
    logic             zero_pend;   // B=0 accepted, result loads on the next edge
    logic             zero_b;
    logic             accept;

    assign zero_b = (B == '0);

    // A pending zero-divisor operation is in flight, so IDLE only accepts
    // when nothing is pending.
    assign accept = start && (((state == ST_IDLE) && !zero_pend) || (state == ST_DONE));

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial      (partial),
        .dividend_bit (dividend[WIDTH-1]),
        .divisor      (divisor),
        .next_partial (step_partial),
        .q_bit        (q_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (zero_pend) begin
                    state_next = ST_DONE;
                end else if (accept && !zero_b) begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (count == LAST_STEP) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept && !zero_b) begin
                    state_next = ST_CALC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: all datapath registers are small flops, so all are reset; an
    // aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend    <= '0;
            divisor     <= '0;
            partial     <= '0;
            count       <= '0;
            zero_pend   <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dividend  <= A;
            divisor   <= B;
            partial   <= '0;
            count     <= '0;
            zero_pend <= zero_b;
        end else if (zero_pend) begin
            zero_pend   <= 1'b0;
            Q           <= '1;
            R           <= dividend;
            div_by_zero <= 1'b1;
        end else if (state == ST_CALC) begin
            partial  <= step_partial;
            dividend <= {dividend[WIDTH-2:0], q_bit};
            count    <= count + CNT_W'(1);
            if (count == LAST_STEP) begin
                Q           <= {dividend[WIDTH-2:0], q_bit};
                R           <= step_partial;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_div_4bit_seq.sv
// Self-checking bench for div_4bit_seq: directed cases, randomized operations
// and a full 256-pair sweep, all compared against a plain-arithmetic model.
module tb_div_4bit_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    div_4bit_seq #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .R           (R),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Launch one operation from a falling edge with the DUT idle or in DONE,
    // then follow it to its done pulse. Inputs are scrambled after acceptance
    // and spurious starts are thrown at it while busy.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_dbz;
        int         lat;
        int         busy_cnt;
        bit         seen;

        exp_dbz = (b == 4'd0);
        exp_q   = exp_dbz ? 4'hF : 4'(a / b);
        exp_r   = exp_dbz ? a    : 4'(a % b);

        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = 4'($urandom);
        B = 4'($urandom);
        lat = 1;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy === 1'b1) begin
                    busy_cnt++;
                    start = 1'($urandom_range(0, 1));
                    A = 4'($urandom);
                    B = 4'($urandom);
                end
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                lat++;
            end
        end

        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency",     32'(lat),         exp_dbz ? 32'd2 : 32'd5);
            check("busy_cycles", 32'(busy_cnt),    exp_dbz ? 32'd0 : 32'd4);
            check("Q",           32'(Q),           32'(exp_q));
            check("R",           32'(R),           32'(exp_r));
            check("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
            if (!exp_dbz) begin
                check("invariant", 32'((32'(Q) * 32'(b) + 32'(R) == 32'(a)) && (R < b)), 32'd1);
            end
        end

        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_not_busy",  32'(busy), 32'd0);
    endtask

    initial begin
        int dones;

        rst_n = 1'b1;
        start = 1'b0;
        A = 4'd0;
        B = 4'd0;
        #1 rst_n = 1'b0;
        #3;
        check("rst_Q",    32'(Q),           32'd0);
        check("rst_R",    32'(R),           32'd0);
        check("rst_busy", 32'(busy),        32'd0);
        check("rst_done", 32'(done),        32'd0);
        check("rst_dbz",  32'(div_by_zero), 32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First accept on the first rising edge after reset release.
        run_op(4'd13, 4'd4);
        run_op(4'd15, 4'd1);
        run_op(4'd3,  4'd7);
        run_op(4'd0,  4'd5);
        run_op(4'd9,  4'd0);
        run_op(4'd8,  4'd2);

        // start held high: back-to-back results every 5 cycles.
        A = 4'd14;
        B = 4'd3;
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("b2b_done", 32'(done), 32'((k % 5) == 0));
            check("b2b_busy", 32'(busy), 32'((k % 5) != 0));
            if ((k % 5) == 0) begin
                check("b2b_Q", 32'(Q), 32'd4);
                check("b2b_R", 32'(R), 32'd2);
            end
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_end_done", 32'(done), 32'd0);
        check("b2b_end_busy", 32'(busy), 32'd0);

        // Reset during the second CALC cycle aborts the operation.
        A = 4'd11;
        B = 4'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_Q",    32'(Q),           32'd0);
        check("abort_R",    32'(R),           32'd0);
        check("abort_busy", 32'(busy),        32'd0);
        check("abort_done", 32'(done),        32'd0);
        check("abort_dbz",  32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(4'd6, 4'd2);

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Exhaustive sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
